instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the instruction decoder. It holds the program counter and issues word reads to instruction memory over a req/ack handshake. It latches the returned word into the instruction register, whose output drives the decoder's 16-bit instruction input. It also handles stalls and branch redirects, flushing any in-flight fetch.

Parameters:
ADDR_W, 16, instruction memory word-address width; PC width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; asynchronous, active-high
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  word address of current request
imem_ack  in  1  memory response strobe, one cycle; imem_rdata valid this cycle
imem_rdata  in  16  fetched instruction word
ir_out  out  16  instruction register, to decoder input A
ir_valid  out  1  ir_out holds an unconsumed instruction
ir_ready  in  1  downstream consumes ir_out this cycle
stall  in  1  blocks consumption, overrides ir_ready
branch_en  in  1  redirect request, one cycle
branch_target  in  ADDR_W  redirect address
pc_out  out  ADDR_W  address of the instruction held in ir_out
retire_cnt  out  16  count of consumed instructions

Behaviour:
- Clocking and reset: one clock (clk); reset rst is asynchronous, active-high.
- Reset values (immediate on rst=1, independent of clk): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ir_out=0, ir_valid=0, pc_out=0, retire_cnt=0. Reset during any state, including mid-handshake, abandons the transaction without waiting for ack.
- States: IDLE, FETCH, HOLD, FLUSH.
- imem_req is 1 in FETCH and FLUSH, 0 otherwise. imem_addr=pc in FETCH; it holds the in-flight address in FLUSH.
- Memory handshake:
  - Address stays stable from req rise until the ack cycle.
  - ack may arrive in the first req cycle, giving a 1-cycle fetch.
  - ack outside FETCH/FLUSH is ignored.
- "consume" = ir_valid & ir_ready & ~stall.
- IDLE -> FETCH on the first clk edge with rst=0.
- FETCH:
  - branch_en=1 with no ack: pc<=branch_target; if req was asserted this cycle, go to FLUSH.
  - ack & ~branch_en: ir_out<=imem_rdata, pc_out<=pc, pc<=pc+1 (mod 2^ADDR_W, 0xFFFF wraps to 0x0000), ir_valid<=1, go to HOLD.
  - ack & branch_en in the same cycle: data dropped, pc<=branch_target, stay in FETCH (new request next cycle). ir_valid stays 0.
- HOLD:
  - ir_valid=1; ir_out and pc_out are stable.
  - On consume: ir_valid<=0, retire_cnt<=retire_cnt+1 (wraps), go to FETCH.
  - With stall=1, stay in HOLD regardless of ir_ready.
  - branch_en: pc<=branch_target, ir_valid<=0, go to FETCH, no retire increment. If consume and branch_en coincide, the consume counts (retire_cnt increments) and the branch also applies.
- FLUSH:
  - Waits for ack of the abandoned request; data is discarded and ir_out is not written.
  - A further branch_en in FLUSH overwrites pc (latest target wins).
  - On ack go to FETCH; the next request goes to the latest target.
- Throughput with a 1-cycle-ack memory and ir_ready=1, no stalls: one instruction per 2 cycles (FETCH, HOLD).
- ir_out is written only on an accepted ack. No combinational path from imem_rdata to ir_out.

Test Plan:
- Reset/boot: RESET_PC=0x0000, memory acks same cycle, rdata=0x1234 at addr 0 -> after rst falls, IDLE then FETCH with imem_addr=0; next cycle ir_out=0x1234, ir_valid=1, pc_out=0x0000; then imem_addr=0x0001.
- Stall hold: ir_valid=1, ir_ready=1, stall=1 for 5 cycles -> ir_out unchanged, imem_req=0, retire_cnt unchanged; stall=0 -> retire_cnt+1, request to pc_out+1.
- Branch in HOLD: ir_out holds instr at 0x0010, branch_en=1 with target 0x0100 -> ir_valid=0 next cycle, imem_addr=0x0100, retire_cnt unchanged.
- Flush: memory with 3-cycle ack latency, branch_en to 0x0200 one cycle after req to 0x0005 -> addr stays 0x0005 until ack, rdata discarded (ir_out unchanged), then req at 0x0200. Second branch to 0x0300 during FLUSH -> request goes to 0x0300.
- Coincident ack and branch in FETCH: ack with rdata=0xBEEF and branch_en to 0x0040 in the same cycle -> ir_valid stays 0, next request at 0x0040, 0xBEEF never appears on ir_out.
- Wrap and async reset: pc=0xFFFF fetched -> next imem_addr=0x0000. Then assert rst mid-FLUSH between edges -> imem_req drops immediately, all outputs at reset values.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches 16-bit words over a req/ack handshake and
// presents them to the decoder through the instruction register.
module instr_fetch_unit #(
  parameter int unsigned          ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       ir_out,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [15:0]       retire_cnt
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;
  localparam logic [1:0] StFlush = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] flush_addr_q, flush_addr_d;
  logic [15:0]       ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [15:0]       retire_q, retire_d;
  logic              consume;

  assign consume = ir_valid_q & ir_ready & ~stall;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flush_addr_d = flush_addr_q;
    ir_d         = ir_q;
    ir_valid_d   = ir_valid_q;
    pc_out_d     = pc_out_q;
    retire_d     = retire_q;
    case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (imem_ack) begin
          if (branch_en) begin
            // Data arriving with a redirect belongs to the wrong path; drop it.
            pc_d = branch_target;
          end else begin
            ir_d       = imem_rdata;
            pc_out_d   = pc_q;
            pc_d       = pc_q + ADDR_W'(1);
            ir_valid_d = 1'b1;
            state_d    = StHold;
          end
        end else if (branch_en) begin
          // Request is in flight: remember its address until the ack drains it.
          pc_d         = branch_target;
          flush_addr_d = pc_q;
          state_d      = StFlush;
        end
      end
      StHold: begin
        if (consume) begin
          ir_valid_d = 1'b0;
          retire_d   = retire_q + 16'd1;
          state_d    = StFetch;
        end
        if (branch_en) begin
          pc_d       = branch_target;
          ir_valid_d = 1'b0;
          state_d    = StFetch;
        end
      end
      StFlush: begin
        if (branch_en) pc_d = branch_target;
        if (imem_ack) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      flush_addr_q <= RESET_PC;
      ir_q         <= '0;
      ir_valid_q   <= 1'b0;
      pc_out_q     <= '0;
      retire_q     <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flush_addr_q <= flush_addr_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      pc_out_q     <= pc_out_d;
      retire_q     <= retire_d;
    end
  end

  assign imem_req   = (state_q == StFetch) || (state_q == StFlush);
  assign imem_addr  = (state_q == StFlush) ? flush_addr_q : pc_q;
  assign ir_out     = ir_q;
  assign ir_valid   = ir_valid_q;
  assign pc_out     = pc_out_q;
  assign retire_cnt = retire_q;

endmodule
